// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RV32 core.
//
// Drives the hold/squash controls of the IF/ID, ID/EX and EX/MEM buffers and
// the fetch PC hold. Handles data-memory wait states, EX-resolved redirects
// and load-use hazards, in that priority order. Stall/flush outputs are
// combinational from the FSM state and the current inputs, and are forced low
// while rst_n is asserted.
//
// Parameters:
//   LOAD_LAT    bubbles per load-use hazard (1..3)
//   MEM_TIMEOUT consecutive wait cycles before mem_timeout is raised
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   id_rs1/id_rs2, id_uses_rs1/2  source registers of the ID instruction
//   ex_rd, ex_MemRead             destination / load flag of the EX instruction
//   ex_redirect                   EX resolved a taken branch or jump
//   mem_req, mem_ready            MEM stage access handshake
//   pc_stall, *_stall, *_flush    pipeline control outputs
//   mem_timeout                   sticky memory-wait timeout flag
//   perf_stall_cnt/perf_flush_cnt performance counters
//
// Optional feature macro: HAZARD_PERF_EN builds the performance counters;
// without it both counter ports are tied to zero.

module hazard_ctrl #(
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned MEM_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_MemRead,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic        mem_timeout,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    localparam int unsigned LU_W   = 2;
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    state_e              ret_q, ret_d;
    state_e              cur_st;
    logic [LU_W-1:0]     lu_cnt_q, lu_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                timeout_q, timeout_d;

    logic mem_hold;
    logic load_use;
    logic pc_stall_c, if_id_stall_c, if_id_flush_c;
    logic id_ex_stall_c, id_ex_flush_c, ex_mem_stall_c;

    // Hazard detection; x0 never produces a hazard.
    assign mem_hold = mem_req && !mem_ready;
    assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            ret_q      <= ST_RUN;
            lu_cnt_q   <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_d        = state_q;
        ret_d          = ret_q;
        lu_cnt_d       = lu_cnt_q;
        wait_cnt_d     = '0;
        timeout_d      = timeout_q;
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_stall_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_stall_c = 1'b0;

        // While waiting on memory the rules of the frozen state apply on release.
        cur_st = (state_q == ST_MEM_WAIT) ? ret_q : state_q;

        if (mem_hold) begin
            pc_stall_c     = 1'b1;
            if_id_stall_c  = 1'b1;
            id_ex_stall_c  = 1'b1;
            ex_mem_stall_c = 1'b1;
            state_d        = ST_MEM_WAIT;
            if (state_q != ST_MEM_WAIT) begin
                ret_d = state_q;
            end
            if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
            if (wait_cnt_d == WAIT_W'(MEM_TIMEOUT)) begin
                timeout_d = 1'b1;
            end
        end else if (ex_redirect) begin
            // Redirect squashes younger work and cancels any load-use bubble.
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            state_d       = ST_RUN;
            lu_cnt_d      = '0;
        end else if (cur_st == ST_LU_STALL) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
            lu_cnt_d      = lu_cnt_q - LU_W'(1);
            state_d       = (lu_cnt_q == LU_W'(1)) ? ST_RUN : ST_LU_STALL;
        end else if (load_use) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
            if (LOAD_LAT > 1) begin
                state_d  = ST_LU_STALL;
                lu_cnt_d = LU_W'(LOAD_LAT - 1);
            end else begin
                state_d  = ST_RUN;
            end
        end else begin
            state_d = ST_RUN;
        end
    end

    // Reset forces every control low immediately, independent of the inputs.
    assign pc_stall     = rst_n & pc_stall_c;
    assign if_id_stall  = rst_n & if_id_stall_c;
    assign if_id_flush  = rst_n & if_id_flush_c;
    assign id_ex_stall  = rst_n & id_ex_stall_c;
    assign id_ex_flush  = rst_n & id_ex_flush_c;
    assign ex_mem_stall = rst_n & ex_mem_stall_c;
    assign mem_timeout  = timeout_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] perf_stall_q;
    logic [CNT_W-1:0] perf_flush_q;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (pc_stall) begin
                perf_stall_q <= perf_stall_q + CNT_W'(1);
            end
            if (if_id_flush) begin
                perf_flush_q <= perf_flush_q + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cnt = CNT_W'(0);
    assign perf_flush_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. Two instances share the
// same stimulus: dut_a with LOAD_LAT=1, dut_b with LOAD_LAT=2, both with
// MEM_TIMEOUT=8. Expected control vectors are queued as stimulus is driven
// and compared when the outputs are sampled on the falling edge.
//
// Control vector bit order: {pc_stall, if_id_stall, if_id_flush,
//                            id_ex_stall, id_ex_flush, ex_mem_stall}

module tb_hazard_ctrl;

    localparam logic [5:0] V_NONE = 6'b000000;
    localparam logic [5:0] V_LU   = 6'b110010;
    localparam logic [5:0] V_RD   = 6'b001010;
    localparam logic [5:0] V_HOLD = 6'b110101;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_MemRead, ex_redirect;
    logic        mem_req, mem_ready;

    logic        a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_stall;
    logic        a_id_ex_flush, a_ex_mem_stall, a_mem_timeout;
    logic [31:0] a_perf_stall, a_perf_flush;
    logic        b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_stall;
    logic        b_id_ex_flush, b_ex_mem_stall, b_mem_timeout;
    logic [31:0] b_perf_stall, b_perf_flush;

    logic [5:0]  a_vec, b_vec;
    assign a_vec = {a_pc_stall, a_if_id_stall, a_if_id_flush,
                    a_id_ex_stall, a_id_ex_flush, a_ex_mem_stall};
    assign b_vec = {b_pc_stall, b_if_id_stall, b_if_id_flush,
                    b_id_ex_stall, b_id_ex_flush, b_ex_mem_stall};

    hazard_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(a_pc_stall), .if_id_stall(a_if_id_stall),
        .if_id_flush(a_if_id_flush), .id_ex_stall(a_id_ex_stall),
        .id_ex_flush(a_id_ex_flush), .ex_mem_stall(a_ex_mem_stall),
        .mem_timeout(a_mem_timeout),
        .perf_stall_cnt(a_perf_stall), .perf_flush_cnt(a_perf_flush)
    );

    hazard_ctrl #(.LOAD_LAT(2), .MEM_TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall),
        .if_id_flush(b_if_id_flush), .id_ex_stall(b_id_ex_stall),
        .id_ex_flush(b_id_ex_flush), .ex_mem_stall(b_ex_mem_stall),
        .mem_timeout(b_mem_timeout),
        .perf_stall_cnt(b_perf_stall), .perf_flush_cnt(b_perf_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [5:0] a;
        logic [5:0] b;
        logic       to;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned stall_a  = 0, stall_b = 0, flush_a = 0, flush_b = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic mr, input logic redir,
                          input logic req, input logic rdy);
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        ex_rd       = rd;
        ex_MemRead  = mr;
        ex_redirect = redir;
        mem_req     = req;
        mem_ready   = rdy;
    endtask

    task automatic idle_in();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_exp(input string tag, input logic [5:0] ea,
                            input logic [5:0] eb, input logic eto);
        exp_t e;
        e.tag = tag;
        e.a   = ea;
        e.b   = eb;
        e.to  = eto;
        sb_q.push_back(e);
    endtask

    // Pop the oldest expectation, compare, then account for counter events.
    task automatic compare();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check({e.tag, "/a_ctl"}, 32'(a_vec), 32'(e.a));
        check({e.tag, "/b_ctl"}, 32'(b_vec), 32'(e.b));
        check({e.tag, "/a_to"}, 32'(a_mem_timeout), 32'(e.to));
        check({e.tag, "/b_to"}, 32'(b_mem_timeout), 32'(e.to));
`ifdef HAZARD_PERF_EN
        check({e.tag, "/a_pstall"}, a_perf_stall, stall_a);
        check({e.tag, "/b_pstall"}, b_perf_stall, stall_b);
        check({e.tag, "/a_pflush"}, a_perf_flush, flush_a);
        check({e.tag, "/b_pflush"}, b_perf_flush, flush_b);
`else
        check({e.tag, "/a_pstall"}, a_perf_stall, 32'd0);
        check({e.tag, "/b_pflush"}, b_perf_flush, 32'd0);
`endif
        if (rst_n) begin
            stall_a += 32'(e.a[5]);
            stall_b += 32'(e.b[5]);
            flush_a += 32'(e.a[3]);
            flush_b += 32'(e.b[3]);
        end
    endtask

    // One cycle: inputs are already driven; queue, sample at negedge, advance.
    task automatic step(input string tag, input logic [5:0] ea,
                        input logic [5:0] eb, input logic eto);
        push_exp(tag, ea, eb, eto);
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        @(posedge clk);
        #1;

        // Reset with random inputs: everything low.
        for (int i = 0; i < 4; i++) begin
            set_in(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                   5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom));
            step("reset", V_NONE, V_NONE, 1'b0);
        end
        rst_n = 1'b1;
        idle_in();
        step("post_reset", V_NONE, V_NONE, 1'b0);

        // Load-use on rs1: one bubble for a, two for b.
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu_rs1", V_LU, V_LU, 1'b0);
        idle_in();
        step("lu_rs1_2nd", V_NONE, V_LU, 1'b0);
        step("lu_rs1_done", V_NONE, V_NONE, 1'b0);

        // x0 never hazards.
        set_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu_x0", V_NONE, V_NONE, 1'b0);

        // Load-use on rs2 with comparators held: b ignores them in LU_STALL.
        set_in(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu_rs2", V_LU, V_LU, 1'b0);
        step("lu_rs2_held", V_LU, V_LU, 1'b0);
        idle_in();
        step("lu_rs2_done", V_NONE, V_NONE, 1'b0);

        // Matching index but operand not used.
        set_in(5'd9, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu_unused", V_NONE, V_NONE, 1'b0);

        // Redirect overrides load-use and prevents LU_STALL entry.
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        step("redir_lu", V_RD, V_RD, 1'b0);
        idle_in();
        step("redir_lu_after", V_NONE, V_NONE, 1'b0);

        // Redirect while b sits in LU_STALL cancels the remaining bubble.
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu_then_redir", V_LU, V_LU, 1'b0);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("redir_in_lu", V_RD, V_RD, 1'b0);
        idle_in();
        step("redir_in_lu_after", V_NONE, V_NONE, 1'b0);

        // Memory wait with a pending redirect applied on release.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step("mw_redir_hold", V_HOLD, V_HOLD, 1'b0);
        end
        mem_ready = 1'b1;
        step("mw_redir_release", V_RD, V_RD, 1'b0);
        idle_in();
        step("mw_redir_after", V_NONE, V_NONE, 1'b0);

        // Memory wait while b is in LU_STALL: the bubble resumes on release.
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("mw_lu_enter", V_LU, V_LU, 1'b0);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("mw_lu_hold", V_HOLD, V_HOLD, 1'b0);
        step("mw_lu_hold", V_HOLD, V_HOLD, 1'b0);
        mem_ready = 1'b1;
        step("mw_lu_release", V_NONE, V_LU, 1'b0);
        idle_in();
        step("mw_lu_after", V_NONE, V_NONE, 1'b0);

        // Timeout: flag visible once 8 wait cycles have elapsed, then sticky.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step("to_hold", V_HOLD, V_HOLD, (i >= 9) ? 1'b1 : 1'b0);
        end
        mem_ready = 1'b1;
        step("to_release", V_NONE, V_NONE, 1'b1);
        idle_in();
        step("to_sticky", V_NONE, V_NONE, 1'b1);

        // Asynchronous reset in the middle of a stall.
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("pre_rst_lu", V_LU, V_LU, 1'b1);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        stall_a = 0;
        stall_b = 0;
        flush_a = 0;
        flush_b = 0;
        push_exp("mid_rst", V_NONE, V_NONE, 1'b0);
        compare();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_in();
        step("mid_rst_after", V_NONE, V_NONE, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32 core.
- Drives the stall/flush inputs of the IF/ID, ID/EX and EX/MEM pipeline buffers and the PC-hold input of the fetch stage.
- Detects load-use hazards, control redirects resolved in EX, and data-memory wait states.
- Sequences multi-cycle stalls with a small FSM and counters.

Parameters:
- LOAD_LAT, 1: bubbles inserted per load-use hazard (1 with MEM->EX forwarding, 2 without); legal range 1-3.
- MEM_TIMEOUT, 1024: consecutive MEM_WAIT cycles before mem_timeout is raised.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  rs1 index of instruction in ID
- id_rs2  in  5  rs2 index of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination register of instruction in EX
- ex_MemRead  in  1  EX instruction is a load
- ex_redirect  in  1  EX resolved taken branch, JAL or JALR this cycle
- mem_req  in  1  MEM stage has an outstanding data access
- mem_ready  in  1  data memory completes access this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID buffer
- if_id_flush  out  1  squash IF/ID buffer
- id_ex_stall  out  1  hold ID/EX buffer
- id_ex_flush  out  1  insert bubble into ID/EX
- ex_mem_stall  out  1  hold EX/MEM buffer
- mem_timeout  out  1  sticky: memory wait exceeded MEM_TIMEOUT
- perf_stall_cnt  out  32  stall-cycle counter (optional feature)
- perf_flush_cnt  out  32  redirect-flush counter (optional feature)

Behaviour:
- FSM states: RUN, LU_STALL, MEM_WAIT. Reset -> RUN.
- Reset values: lu_cnt=0, wait_cnt=0, mem_timeout=0, perf counters=0.
- Outputs are combinational from state plus current inputs. In RUN with no hazard, all stall/flush outputs are 0.
- mem_hold = mem_req && !mem_ready.
- load_use = ex_MemRead && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- Priority, highest first: mem_hold, then redirect, then load-use / LU_STALL.
- mem_hold (any state):
  - Assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall. All flushes 0.
  - Go to MEM_WAIT; the current state is frozen, including lu_cnt.
  - The held EX instruction keeps ex_redirect asserted, so the redirect is applied on the release cycle; nothing is latched.
- MEM_WAIT:
  - wait_cnt increments each cycle, saturating.
  - When wait_cnt reaches MEM_TIMEOUT, set mem_timeout (sticky until reset).
  - When mem_ready=1, return to the frozen pre-wait state (RUN or LU_STALL) and clear wait_cnt. The release cycle applies the normal RUN/LU_STALL output rules.
- Redirect (ex_redirect && !mem_hold):
  - Assert if_id_flush and id_ex_flush. pc_stall=0 so the target loads.
  - Overrides load-use; clears LU_STALL and forces RUN.
- Load-use in RUN (no mem_hold, no redirect):
  - Assert pc_stall, if_id_stall, id_ex_flush (bubble).
  - If LOAD_LAT>1, go to LU_STALL with lu_cnt=LOAD_LAT-1.
- LU_STALL:
  - Same outputs as a load-use in RUN, regardless of the comparators; decrement lu_cnt.
  - Go to RUN when lu_cnt reaches 1 at the decrement.
- x0 never causes a hazard.
- Reset mid-stall returns to RUN with all outputs 0 immediately (asynchronous).

Optional Feature:
- HAZARD_PERF_EN defined:
  - perf_stall_cnt increments every cycle that pc_stall=1.
  - perf_flush_cnt increments every cycle that a redirect flush is asserted.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- HAZARD_PERF_EN undefined: both ports tied to 0 and no counter flops are built.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0; release -> RUN, outputs 0.
- Load-use, LOAD_LAT=1: ex_MemRead=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> exactly 1 cycle of pc_stall=if_id_stall=id_ex_flush=1. Repeat with ex_rd=0 -> no stall.
- Load-use, LOAD_LAT=2: same stimulus, comparators cleared next cycle -> 2 consecutive bubble cycles, then RUN.
- Redirect plus load-use in the same cycle -> if_id_flush=id_ex_flush=1, pc_stall=0, no LU_STALL entry.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles with ex_redirect=1 -> 4 cycles of all four stalls with flushes 0. On the mem_ready=1 cycle -> flushes=1, stalls=0.
- Timeout: MEM_TIMEOUT=8, mem_ready held 0 for 10 cycles -> mem_timeout rises at cycle 8 and stays 1 after mem_ready; perf_stall_cnt=10 with HAZARD_PERF_EN defined.
